// File: rtl/transpose_seq.sv
`default_nettype none
// ============================================================================
// Module   : transpose_seq
// Purpose  : Streams 16-bit words into a memory-mapped 4-register transposer,
//            then reads the transposed words back out with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module transpose_seq #(
    parameter logic [13:0] BASE_ADDR = 14'h88,
    parameter int          CNT_W     = 8
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             abort,
    output logic [13:0]      m_addr,
    output logic [15:0]      m_din,
    output logic             m_en,
    output logic [1:0]       m_we,
    input  logic [15:0]      m_dout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_blk_cnt;
    logic             w_ld_out;
    logic             w_clr_out;
    logic             w_blk_end;
    logic [13:0]      w_reg_addr;

    assign w_reg_addr = BASE_ADDR + {12'd0, r_idx};

    // Input is also refused while reset is held so no write leaks onto the bus.
    assign in_ready  = puc_rst_n & ~abort & (r_state == LOAD);
    assign busy      = !((r_state == LOAD) && (r_idx == 2'd0));
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign blk_cnt   = r_blk_cnt;

    always_comb begin
        w_next    = r_state;
        w_idx_nxt = r_idx;
        m_en      = 1'b0;
        m_we      = 2'b00;
        m_addr    = 14'd0;
        m_din     = 16'd0;
        w_ld_out  = 1'b0;
        w_clr_out = 1'b0;
        w_blk_end = 1'b0;
        if (abort) begin
            w_next    = LOAD;
            w_idx_nxt = 2'd0;
            w_clr_out = 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (in_valid && puc_rst_n) begin
                        m_en      = 1'b1;
                        m_we      = 2'b11;
                        m_addr    = w_reg_addr;
                        m_din     = in_data;
                        w_idx_nxt = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_next = READ;
                        end
                    end
                end
                READ: begin
                    if (puc_rst_n) begin
                        m_en   = 1'b1;
                        m_addr = w_reg_addr;
                    end
                    w_ld_out = 1'b1;
                    w_next   = DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        w_clr_out = 1'b1;
                        if (r_idx == 2'd3) begin
                            w_idx_nxt = 2'd0;
                            w_blk_end = 1'b1;
                            w_next    = LOAD;
                        end else begin
                            w_idx_nxt = r_idx + 2'd1;
                            w_next    = READ;
                        end
                    end
                end
                default: begin
                    w_next    = LOAD;
                    w_idx_nxt = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_state     <= LOAD;
            r_idx       <= 2'd0;
            r_out_data  <= 16'd0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nxt;
            r_done  <= w_blk_end;
            if (w_ld_out) begin
                r_out_data  <= m_dout;
                r_out_valid <= 1'b1;
            end else if (w_clr_out) begin
                r_out_valid <= 1'b0;
            end
            if (w_blk_end) begin
                r_blk_cnt <= r_blk_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transpose_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_transpose_seq
// Purpose  : Self-checking bench with a transposer peripheral model and a
//            block-level scoreboard for transpose_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transpose_seq;

    localparam logic [13:0] c_base = 14'h88;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] m_addr;
    logic [15:0] m_din;
    logic        m_en;
    logic [1:0]  m_we;
    logic [15:0] m_dout;
    logic        busy;
    logic        done;
    logic [7:0]  blk_cnt;

    int errors = 0;
    int checks = 0;

    always #5 mclk = ~mclk;

    transpose_seq #(.BASE_ADDR(14'h88), .CNT_W(8)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .abort(abort),
        .m_addr(m_addr), .m_din(m_din), .m_en(m_en), .m_we(m_we), .m_dout(m_dout),
        .busy(busy), .done(done), .blk_cnt(blk_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // 8x8 bit matrix: byte r of the packed 64-bit block is row r, MSB is column 0.
    function automatic logic [63:0] transp(input logic [63:0] m);
        logic [63:0] t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[63 - 8*r - c] = m[63 - 8*c - r];
        return t;
    endfunction

    // Transposer peripheral: four writable registers, combinational transposed read.
    logic [15:0] treg [4];
    logic [13:0] w_off;
    logic [63:0] w_tblk;
    assign w_off  = m_addr - c_base;
    assign w_tblk = transp({treg[0], treg[1], treg[2], treg[3]});

    initial for (int i = 0; i < 4; i++) treg[i] = 16'd0;

    always @(posedge mclk)
        if (m_en && m_we == 2'b11 && w_off < 14'd4) treg[w_off[1:0]] <= m_din;

    always_comb begin
        m_dout = 16'd0;
        if (m_en && m_we == 2'b00 && w_off < 14'd4)
            m_dout = w_tblk[63 - 16*w_off[1:0] -: 16];
    end

    // Scoreboard state.
    logic [15:0] part [4];
    int          part_n = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    logic [13:0] wr_q [$];
    int          model_cnt = 0;
    int          done_seen = 0;
    bit          pend_done = 1'b0;
    int          lat_cd = 0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_od = 16'd0;

    always @(negedge mclk) begin
        logic        exp_ir;
        logic [46:0] exp_bus;
        logic [63:0] blk;
        if (!puc_rst_n) begin
            chk("reset_outputs",
                {out_data, out_valid, done, blk_cnt, busy, m_en, m_we, m_addr, m_din, in_ready},
                64'd0);
            part_n = 0; exp_q.delete(); model_cnt = 0; pend_done = 0;
            lat_cd = 0; prev_hold = 0;
        end else begin
            if (done) done_seen++;
            exp_ir = !abort && exp_q.size() == 0;
            chk("done", done, pend_done);
            chk("blk_cnt", blk_cnt, model_cnt[7:0]);
            chk("busy", busy, (part_n != 0) || (exp_q.size() != 0));
            chk("in_ready", in_ready, exp_ir);
            if (exp_q.size() == 0) chk("valid_no_data", out_valid, 1'b0);
            if (lat_cd == 1) chk("latency", out_valid, 1'b1);
            if (prev_hold) chk("hold", {out_valid, out_data}, {1'b1, prev_od});
            exp_bus = '0;
            if (in_valid && exp_ir)
                exp_bus = {1'b1, 2'b11, c_base + 14'(part_n), in_data};
            else if (!abort && !out_valid && exp_q.size() != 0)
                exp_bus = {1'b1, 2'b00, c_base + 14'(4 - exp_q.size()), 16'd0};
            chk("bus", {m_en, m_we, m_addr, m_din}, exp_bus);
            if (m_en && m_we == 2'b11) wr_q.push_back(m_addr);

            pend_done = 0;
            if (lat_cd > 0) lat_cd--;
            if (abort) begin
                part_n = 0; exp_q.delete(); lat_cd = 0;
            end else begin
                if (in_valid && exp_ir) begin
                    part[part_n] = in_data;
                    part_n++;
                    if (part_n == 4) begin
                        blk = transp({part[0], part[1], part[2], part[3]});
                        for (int w = 0; w < 4; w++) exp_q.push_back(blk[63 - 16*w -: 16]);
                        part_n = 0;
                        lat_cd = 2;
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    chk("out_data", out_data, exp_q[0]);
                    obs_q.push_back(out_data);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        pend_done = 1;
                        model_cnt++;
                    end
                end
            end
            prev_hold = out_valid && !out_ready && !abort;
            prev_od   = out_data;
        end
    end

    task automatic step();
        @(posedge mclk); #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 200; k++) begin
            @(negedge mclk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("push_timeout", 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] a, b, c, d);
        push_word(a); push_word(b); push_word(c); push_word(d);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (!busy) begin ok = 1; break; end
        end
        chk("idle_timeout", ok, 1'b1);
        step(); step();
    endtask

    task automatic chk_obs(input string name, input logic [15:0] a, b, c, d);
        chk({name, "_count"}, obs_q.size(), 4);
        if (obs_q.size() == 4)
            chk(name, {obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, {a, b, c, d});
    endtask

    initial begin
        int base_done;
        int base_cnt;
        bit ok;
        repeat (3) step();
        puc_rst_n = 1'b1;
        step();
        chk("reset_release", {in_ready, busy, blk_cnt}, {1'b1, 1'b0, 8'd0});

        // All-ones first word transposes into the top two columns.
        out_ready = 1'b1;
        obs_q.delete();
        send_block(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        wait_idle();
        chk_obs("blk_c0c0", 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0);
        chk("blk_c0c0_cnt", {blk_cnt, 8'(done_seen)}, {8'd1, 8'd1});

        // Single corner bit stays on the diagonal; writes hit consecutive registers.
        obs_q.delete(); wr_q.delete();
        send_block(16'h0000, 16'h0000, 16'h0000, 16'h0001);
        wait_idle();
        chk_obs("blk_diag", 16'h0000, 16'h0000, 16'h0000, 16'h0001);
        chk("wr_addrs", wr_q.size() == 4 ? {wr_q[0], wr_q[1], wr_q[2], wr_q[3]} : 56'd0,
            {14'h88, 14'h89, 14'h8A, 14'h8B});

        // Back-pressure while the first output word is waiting.
        out_ready = 1'b0;
        obs_q.delete();
        send_block(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid) begin ok = 1; break; end
        end
        chk("bp_valid_timeout", ok, 1'b1);
        repeat (5) step();
        chk("bp_stall", {out_valid, in_ready, m_en}, {1'b1, 1'b0, 1'b0});
        out_ready = 1'b1;
        wait_idle();
        chk("bp_words", obs_q.size(), 4);

        // Abort after two words: only the following four words form the block.
        obs_q.delete();
        base_cnt = model_cnt;
        push_word(16'hFFFF); push_word(16'hFFFF);
        abort = 1'b1; step(); abort = 1'b0;
        send_block(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        wait_idle();
        chk_obs("abort_blk", 16'h0000, 16'h0000, 16'h0000, 16'h0040);
        chk("abort_cnt", blk_cnt, 8'(base_cnt + 1));

        // Reset while word 2 is draining.
        obs_q.delete();
        in_valid = 1'b0;
        send_block(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (obs_q.size() == 2) begin ok = 1; break; end
        end
        chk("rst_mid_timeout", ok, 1'b1);
        out_ready = 1'b0;
        repeat (2) step();
        puc_rst_n = 1'b0;
        repeat (2) step();
        puc_rst_n = 1'b1;
        step();
        chk("rst_mid_state", {blk_cnt, out_valid, busy, done}, 11'd0);
        out_ready = 1'b1;
        obs_q.delete();
        send_block(16'h0000, 16'h0000, 16'h0000, 16'h0001);
        wait_idle();
        chk_obs("post_rst_blk", 16'h0000, 16'h0000, 16'h0000, 16'h0001);

        // Randomised traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            abort     = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        wait_idle();
        chk("rand_drained", exp_q.size() + part_n, 0);

        // Counter wrap over 256 blocks from reset.
        puc_rst_n = 1'b0; step(); puc_rst_n = 1'b1; step();
        base_done = done_seen;
        for (int b = 0; b < 256; b++) begin
            send_block(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            wait_idle();
            if (b == 254) chk("cnt_255", blk_cnt, 8'd255);
        end
        chk("cnt_wrap", blk_cnt, 8'd0);
        chk("done_256", done_seen - base_done, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
